usb_line_state_detect: RTL and testbench

//  Clocked, parametrised successor to the combinational SE0 detector. Synchronises raw
//  d_plus/d_minus and decodes full-speed line state (J/K/SE0/SE1). Qualifies a real EOP
//  as SE0 held >= SE0_MIN_CLKS, followed by J held J_CONFIRM_CLKS. Flags malformed EOPs
//  and long-SE0 bus reset. Sits between the USB pins and the RX decoder/packet FSM.

---
 rtl/usb_line_state_detect.sv | 178 +++++++++++++++++
 tb/tb_usb_line_state_detect.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/usb_line_state_detect.sv
// USB full-speed line state decoder with EOP qualification and bus reset detection.
// Raw D+/D- are synchronised, decoded to J/K/SE0/SE1, and tracked by a small FSM.
module usb_line_state_detect #(
  parameter int SYNC_STAGES    = 2,
  parameter int SE0_MIN_CLKS   = 12,
  parameter int J_CONFIRM_CLKS = 8,
  parameter int BUS_RESET_CLKS = 160
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus,
  input  logic d_minus,
  output logic line_j,
  output logic line_k,
  output logic line_se0,
  output logic line_se1,
  output logic eop,
  output logic eop_err,
  output logic bus_reset
);

  localparam int SW = $clog2(BUS_RESET_CLKS + 1);
  localparam int JW = $clog2(J_CONFIRM_CLKS + 1);

  localparam logic [SW-1:0] SE0_MIN = SW'(SE0_MIN_CLKS);
  localparam logic [SW-1:0] SE0_MAX = SW'(BUS_RESET_CLKS);
  localparam logic [JW-1:0] J_MAX   = JW'(J_CONFIRM_CLKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SE0,
    S_JCHK,
    S_RST
  } state_t;

  logic [SYNC_STAGES-1:0] r_dp_sync;
  logic [SYNC_STAGES-1:0] r_dm_sync;

  logic w_dp;
  logic w_dm;
  logic w_j;
  logic w_k;
  logic w_se0;
  logic w_se1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_se0_cnt;
  logic [SW-1:0] w_se0_nxt;
  logic [SW-1:0] w_se0_inc;
  logic [JW-1:0] r_j_cnt;
  logic [JW-1:0] w_j_nxt;
  logic [JW-1:0] w_j_inc;
  logic          r_eop;
  logic          w_eop_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic          r_bus;
  logic          w_bus_nxt;

  // Chains reset to idle J so no spurious SE0 is seen coming out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_sync <= '1;
      r_dm_sync <= '0;
    end else begin
      r_dp_sync <= {r_dp_sync[SYNC_STAGES-2:0], d_plus};
      r_dm_sync <= {r_dm_sync[SYNC_STAGES-2:0], d_minus};
    end
  end

  assign w_dp  = r_dp_sync[SYNC_STAGES-1];
  assign w_dm  = r_dm_sync[SYNC_STAGES-1];
  assign w_j   =  w_dp & ~w_dm;
  assign w_k   = ~w_dp &  w_dm;
  assign w_se0 = ~w_dp & ~w_dm;
  assign w_se1 =  w_dp &  w_dm;

  assign w_se0_inc = r_se0_cnt + SW'(1);
  assign w_j_inc   = r_j_cnt + JW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_se0_nxt   = r_se0_cnt;
    w_j_nxt     = r_j_cnt;
    w_eop_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_bus_nxt   = r_bus;
    unique case (r_state)
      S_IDLE: begin
        if (w_se0) begin
          w_state_nxt = S_SE0;
          w_se0_nxt   = SW'(1);
        end
      end
      S_SE0: begin
        if (w_se0) begin
          if (w_se0_inc >= SE0_MAX) begin
            w_state_nxt = S_RST;
            w_se0_nxt   = SE0_MAX;
            w_bus_nxt   = 1'b1;
          end else begin
            w_se0_nxt = w_se0_inc;
          end
        end else begin
          w_state_nxt = S_IDLE;
          w_se0_nxt   = '0;
          if (r_se0_cnt >= SE0_MIN) begin
            if (!w_j) begin
              w_err_nxt = 1'b1;
            end else if (J_MAX == JW'(1)) begin
              w_eop_nxt = 1'b1;
            end else begin
              w_state_nxt = S_JCHK;
              w_j_nxt     = JW'(1);
            end
          end
        end
      end
      S_JCHK: begin
        if (w_j) begin
          if (w_j_inc == J_MAX) begin
            w_state_nxt = S_IDLE;
            w_j_nxt     = '0;
            w_eop_nxt   = 1'b1;
          end else begin
            w_j_nxt = w_j_inc;
          end
        end else if (w_se0) begin
          w_state_nxt = S_SE0;
          w_se0_nxt   = SW'(1);
          w_j_nxt     = '0;
        end else begin
          w_state_nxt = S_IDLE;
          w_j_nxt     = '0;
          w_err_nxt   = 1'b1;
        end
      end
      S_RST: begin
        if (!w_se0) begin
          w_state_nxt = S_IDLE;
          w_se0_nxt   = '0;
          w_bus_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_se0_cnt <= '0;
      r_j_cnt   <= '0;
      r_eop     <= 1'b0;
      r_err     <= 1'b0;
      r_bus     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_se0_cnt <= w_se0_nxt;
      r_j_cnt   <= w_j_nxt;
      r_eop     <= w_eop_nxt;
      r_err     <= w_err_nxt;
      r_bus     <= w_bus_nxt;
    end
  end

  assign line_j    = w_j;
  assign line_k    = w_k;
  assign line_se0  = w_se0;
  assign line_se1  = w_se1;
  assign eop       = r_eop;
  assign eop_err   = r_err;
  assign bus_reset = r_bus;

endmodule

// File: tb/tb_usb_line_state_detect.sv
// Directed bench for usb_line_state_detect: reset, EOP, glitch, bad EOP,
// bus reset, mid-sequence reset and a line-state sweep.
module tb_usb_line_state_detect;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_plus = 1'b0;
  logic d_minus = 1'b0;
  logic line_j;
  logic line_k;
  logic line_se0;
  logic line_se1;
  logic eop;
  logic eop_err;
  logic bus_reset;

  usb_line_state_detect #(
    .SYNC_STAGES   (SYNC),
    .SE0_MIN_CLKS  (12),
    .J_CONFIRM_CLKS(8),
    .BUS_RESET_CLKS(160)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .d_plus   (d_plus),
    .d_minus  (d_minus),
    .line_j   (line_j),
    .line_k   (line_k),
    .line_se0 (line_se0),
    .line_se1 (line_se1),
    .eop      (eop),
    .eop_err  (eop_err),
    .bus_reset(bus_reset)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int n_eop, n_err, n_both, n_br_hi;
  int eop_cyc, br_rise, br_fall;
  int n_nohot = 0;
  logic mon_en = 1'b0;
  logic br_prev = 1'b0;

  always @(posedge clk) cyc++;

  // Pulse/level bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!$onehot({line_j, line_k, line_se0, line_se1})) n_nohot++;
      if (eop) begin
        n_eop++;
        eop_cyc = cyc;
      end
      if (eop_err) n_err++;
      if (eop && eop_err) n_both++;
      if (bus_reset) n_br_hi++;
      if (bus_reset && !br_prev) br_rise = cyc;
      if (!bus_reset && br_prev) br_fall = cyc;
      br_prev = bus_reset;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_eop   = 0;
    n_err   = 0;
    n_both  = 0;
    n_br_hi = 0;
    eop_cyc = -1;
    br_rise = -1;
    br_fall = -1;
  endtask

  // Set pins just after an edge, then hold for n clocks.
  task automatic drive(input logic dp, input logic dm, input int n);
    d_plus  = dp;
    d_minus = dm;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int lines();
    return int'({line_j, line_k, line_se0, line_se1});
  endfunction

  int t0;
  logic [1:0] sw_pins [4];
  int         sw_code [4];

  initial begin
    clr();
    // 1: reset with SE0 on the pins still shows idle J
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_line_j", int'(line_j), 1);
      chk("rst_line_se0", int'(line_se0), 0);
      chk("rst_eop", int'(eop | eop_err), 0);
      chk("rst_bus_reset", int'(bus_reset), 0);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    drive(1'b1, 1'b0, 5);
    chk("idle_lines", lines(), 4'b1000);

    // 2: valid EOP, 16 SE0 then 10 J
    clr();
    t0 = cyc;
    drive(1'b0, 1'b0, 16);
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b0, 6);
    chk("eop_count", n_eop, 1);
    chk("eop_err_count", n_err, 0);
    chk("eop_latency", eop_cyc - t0, SYNC + 16 + 8);

    // 3: short SE0 glitch
    clr();
    drive(1'b0, 1'b0, 5);
    drive(1'b1, 1'b0, 20);
    chk("glitch_eop", n_eop, 0);
    chk("glitch_err", n_err, 0);

    // 4: SE0 then J interrupted by K
    clr();
    drive(1'b0, 1'b0, 16);
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b0, 12);
    chk("bad_eop_err", n_err, 1);
    chk("bad_eop_eop", n_eop, 0);

    // 5: long SE0 becomes bus reset
    clr();
    t0 = cyc;
    drive(1'b0, 1'b0, 200);
    chk("br_level", int'(bus_reset), 1);
    chk("br_rise", br_rise - t0, SYNC + 160);
    drive(1'b1, 1'b0, 12);
    chk("br_fall", br_fall - t0, 200 + SYNC + 1);
    chk("br_hi_cycles", n_br_hi, 200 + 1 - 160);
    chk("br_eop", n_eop + n_err, 0);
    chk("br_level_after", int'(bus_reset), 0);

    // 6a: reset while confirming J aborts the EOP
    clr();
    drive(1'b0, 1'b0, 16);
    drive(1'b1, 1'b0, 4);
    rst = 1'b1;
    drive(1'b1, 1'b0, 2);
    rst = 1'b0;
    drive(1'b1, 1'b0, 15);
    chk("midrst_eop", n_eop, 0);
    chk("midrst_err", n_err, 0);

    // 6b: sweep all pin combinations, checking the sync delay
    sw_pins[0] = 2'b01; sw_code[0] = 4'b0100;
    sw_pins[1] = 2'b00; sw_code[1] = 4'b0010;
    sw_pins[2] = 2'b11; sw_code[2] = 4'b0001;
    sw_pins[3] = 2'b10; sw_code[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      drive(sw_pins[i][1], sw_pins[i][0], SYNC - 1);
      chk("sweep_lag", lines(), (i == 0) ? 4'b1000 : sw_code[i-1]);
      drive(sw_pins[i][1], sw_pins[i][0], 1);
      chk("sweep_line", lines(), sw_code[i]);
      drive(sw_pins[i][1], sw_pins[i][0], 2);
    end
    drive(1'b1, 1'b0, 4);

    chk("onehot_viol", n_nohot, 0);
    chk("eop_and_err", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
